// File: rtl/bsw_pkg.sv
// Shared codes, enums and default scoring constants for the banded Smith-Waterman aligner.
package bsw_pkg;

    localparam int LEN_DEF      = 8;
    localparam int BAND_DEF     = 1;
    localparam int MATCH_DEF    = 2;
    localparam int MISMATCH_DEF = 1;
    localparam int GAP_DEF      = 1;
    localparam int SW_DEF       = 6;

    localparam logic [2:0] BASE_A  = 3'b000;
    localparam logic [2:0] BASE_C  = 3'b001;
    localparam logic [2:0] BASE_G  = 3'b010;
    localparam logic [2:0] BASE_T  = 3'b011;
    localparam logic [2:0] SYM_GAP = 3'b100;
    localparam logic [2:0] SYM_PAD = 3'b111;

    typedef enum logic [1:0] {PtrZero, PtrDiag, PtrUp, PtrLeft} ptr_e;

    typedef enum logic [1:0] {StIdle, StFill, StTrace, StDone} state_e;

endpackage

// File: rtl/bsw_cell.sv
// One Smith-Waterman cell: max of zero, diagonal, up and left with the traceback pointer.
module bsw_cell
    import bsw_pkg::*;
#(
    parameter int SW       = SW_DEF,
    parameter int MATCH    = MATCH_DEF,
    parameter int MISMATCH = MISMATCH_DEF,
    parameter int GAP      = GAP_DEF
) (
    input  logic signed [SW-1:0] h_diag,
    input  logic signed [SW-1:0] h_up,
    input  logic signed [SW-1:0] h_left,
    input  logic                 is_match,
    output logic signed [SW-1:0] score,
    output logic [1:0]           ptr
);

    localparam logic signed [SW-1:0] MatchS = SW'(MATCH);
    localparam logic signed [SW-1:0] MissS  = SW'(MISMATCH);
    localparam logic signed [SW-1:0] GapS   = SW'(GAP);

    logic signed [SW-1:0] diag, up, left, m;

    always_comb begin
        diag = is_match ? h_diag + MatchS : h_diag - MissS;
        up   = h_up - GapS;
        left = h_left - GapS;
        m    = diag;
        if (up > m)   m = up;
        if (left > m) m = left;
        // A non-positive maximum floors to zero and always gives the ZERO pointer.
        if (m <= 0) begin
            score = '0;
            ptr   = PtrZero;
        end else begin
            score = m;
            if (diag == m)    ptr = PtrDiag;
            else if (up == m) ptr = PtrUp;
            else              ptr = PtrLeft;
        end
    end

endmodule

// File: rtl/banded_sw_accelerator.sv
// Banded Smith-Waterman aligner: row-major band fill, then one traceback column per cycle.
// Optional BSW_SCORE_OUT_EN adds the best_score output.
module banded_sw_accelerator
    import bsw_pkg::*;
#(
    parameter int LEN      = LEN_DEF,
    parameter int BAND     = BAND_DEF,
    parameter int MATCH    = MATCH_DEF,
    parameter int MISMATCH = MISMATCH_DEF,
    parameter int GAP      = GAP_DEF,
    parameter int SW       = SW_DEF
) (
    input  logic                   clk,
    input  logic                   start,
    input  logic [3*LEN-1:0]       R,
    input  logic [3*LEN-1:0]       Q,
    output logic [3*(LEN+1)-1:0]   R_aligned,
    output logic [3*(LEN+1)-1:0]   Q_aligned,
    output logic                   ready
`ifdef BSW_SCORE_OUT_EN
   ,output logic [SW-1:0]          best_score
`endif
);

    localparam int IW = $clog2(LEN + 2);
    localparam int OW = 3 * (LEN + 1);

    typedef logic signed [SW-1:0] score_t;

    state_e           state;
    logic [3*LEN-1:0] r_q, q_q;
    score_t           h_q   [LEN+1][LEN+1];
    logic [1:0]       ptr_q [LEN+1][LEN+1];
    logic [IW-1:0]    i_q, j_q, bi_q, bj_q, cnt_q;
    score_t           best_q;
    logic [OW-1:0]    rbuf_q, qbuf_q;

    logic [IW-1:0] im1, jm1, j_last, j_first;
    logic [2:0]    rb, qb, sym_r, sym_q;
    logic [1:0]    cell_ptr, cur_ptr;
    score_t        cell_score;
    logic          cell_match, at_last_cell, upd, stop;

    function automatic logic [2:0] base_at(input logic [3*LEN-1:0] v, input logic [IW-1:0] k);
        logic [IW-1:0] km1;
        km1 = (k == '0) ? '0 : k - 1'b1;
        return v[int'(km1)*3 +: 3];
    endfunction

    always_comb begin
        im1          = (i_q == '0) ? '0 : i_q - 1'b1;
        jm1          = (j_q == '0) ? '0 : j_q - 1'b1;
        rb           = base_at(r_q, i_q);
        qb           = base_at(q_q, j_q);
        cell_match   = (rb == qb) && !rb[2];
        j_last       = (int'(i_q) + BAND >= LEN) ? IW'(LEN) : i_q + IW'(BAND);
        j_first      = (int'(i_q) >= BAND) ? i_q + 1'b1 - IW'(BAND) : IW'(1);
        at_last_cell = (j_q == j_last) && (i_q == IW'(LEN));
        upd          = cell_score > best_q;
        cur_ptr      = ptr_q[i_q][j_q];
        stop         = (i_q == '0) || (j_q == '0) || (cur_ptr == PtrZero) ||
                       (cnt_q == IW'(LEN + 1));
        sym_r        = (cur_ptr == PtrLeft) ? SYM_GAP : rb;
        sym_q        = (cur_ptr == PtrUp) ? SYM_GAP : qb;
    end

    // Out-of-band cells are never written, so they read back as the reset zero.
    bsw_cell #(
        .SW       (SW),
        .MATCH    (MATCH),
        .MISMATCH (MISMATCH),
        .GAP      (GAP)
    ) u_cell (
        .h_diag   (h_q[im1][jm1]),
        .h_up     (h_q[im1][j_q]),
        .h_left   (h_q[i_q][jm1]),
        .is_match (cell_match),
        .score    (cell_score),
        .ptr      (cell_ptr)
    );

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            state <= StIdle;
            r_q   <= '0;
            q_q   <= '0;
            for (int a = 0; a <= LEN; a++) begin
                for (int b = 0; b <= LEN; b++) begin
                    h_q[a][b]   <= '0;
                    ptr_q[a][b] <= PtrZero;
                end
            end
            i_q       <= IW'(1);
            j_q       <= IW'(1);
            bi_q      <= '0;
            bj_q      <= '0;
            cnt_q     <= '0;
            best_q    <= '0;
            rbuf_q    <= '1;
            qbuf_q    <= '1;
            R_aligned <= '0;
            Q_aligned <= '0;
            ready     <= 1'b0;
`ifdef BSW_SCORE_OUT_EN
            best_score <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    r_q   <= R;
                    q_q   <= Q;
                    state <= StFill;
                end
                StFill: begin
                    h_q[i_q][j_q]   <= cell_score;
                    ptr_q[i_q][j_q] <= cell_ptr;
                    if (upd) begin
                        best_q <= cell_score;
                        bi_q   <= i_q;
                        bj_q   <= j_q;
                    end
                    if (at_last_cell) begin
                        state <= StTrace;
                        i_q   <= upd ? i_q : bi_q;
                        j_q   <= upd ? j_q : bj_q;
                    end else if (j_q == j_last) begin
                        i_q <= i_q + 1'b1;
                        j_q <= j_first;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                StTrace: begin
                    if (stop) begin
                        R_aligned <= rbuf_q;
                        Q_aligned <= qbuf_q;
                        ready     <= 1'b1;
                        state     <= StDone;
`ifdef BSW_SCORE_OUT_EN
                        best_score <= best_q;
`endif
                    end else begin
                        // Columns arrive right to left; shifting up leaves the last one at [2:0].
                        rbuf_q <= {rbuf_q[OW-4:0], sym_r};
                        qbuf_q <= {qbuf_q[OW-4:0], sym_q};
                        cnt_q  <= cnt_q + 1'b1;
                        if (cur_ptr != PtrLeft) i_q <= i_q - 1'b1;
                        if (cur_ptr != PtrUp)   j_q <= j_q - 1'b1;
                    end
                end
                StDone: begin
                    state <= StDone;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_banded_sw_accelerator.sv
// Directed bench for banded_sw_accelerator with a behavioural alignment model and per-cycle compare.
module tb_banded_sw_accelerator;

    logic        clk = 1'b0;
    logic        start = 1'b1;
    logic [23:0] R = '0;
    logic [23:0] Q = '0;
    logic [26:0] R_aligned, Q_aligned;
    logic        ready;
`ifdef BSW_SCORE_OUT_EN
    logic [5:0]  best_score;
`endif

    banded_sw_accelerator dut (
        .clk       (clk),
        .start     (start),
        .R         (R),
        .Q         (Q),
        .R_aligned (R_aligned),
        .Q_aligned (Q_aligned),
        .ready     (ready)
`ifdef BSW_SCORE_OUT_EN
       ,.best_score (best_score)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          edges = 0;
    bit          running = 1'b0;
    logic [26:0] exp_ra, exp_qa;
    int          exp_lat, exp_best;

    localparam logic [23:0] ACGT  = 24'h688688;
    localparam logic [23:0] ONEMM = 24'h688088;
    localparam logic [23:0] ALLC  = 24'h249249;
    localparam logic [23:0] INDEL = 24'h443688;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // Full banded DP, best-cell search and traceback straight from the scoring rules.
    task automatic model(input logic [23:0] r, input logic [23:0] q);
        int h [0:8][0:8];
        int p [0:8][0:8];
        int best, bi, bj, cells, i, j, n, d, u, l, m;
        logic [2:0] rb, qb;
        logic [2:0] col_r[$];
        logic [2:0] col_q[$];
        best = 0; bi = 0; bj = 0; cells = 0;
        for (int a = 0; a <= 8; a++)
            for (int b = 0; b <= 8; b++) begin
                h[a][b] = 0;
                p[a][b] = 0;
            end
        for (int ii = 1; ii <= 8; ii++)
            for (int jj = 1; jj <= 8; jj++)
                if (ii - jj <= 1 && jj - ii <= 1) begin
                    rb = r[3*(ii-1) +: 3];
                    qb = q[3*(jj-1) +: 3];
                    d = h[ii-1][jj-1] + ((rb == qb && rb < 3'd4) ? 2 : -1);
                    u = h[ii-1][jj] - 1;
                    l = h[ii][jj-1] - 1;
                    m = 0;
                    if (d > m) m = d;
                    if (u > m) m = u;
                    if (l > m) m = l;
                    h[ii][jj] = m;
                    p[ii][jj] = (m == 0) ? 0 : (m == d) ? 1 : (m == u) ? 2 : 3;
                    cells++;
                    if (m > best) begin
                        best = m; bi = ii; bj = jj;
                    end
                end
        i = bi; j = bj; n = 0;
        while (i > 0 && j > 0 && p[i][j] != 0 && n < 9) begin
            rb = r[3*(i-1) +: 3];
            qb = q[3*(j-1) +: 3];
            case (p[i][j])
                1: begin col_r.push_back(rb); col_q.push_back(qb); i--; j--; end
                2: begin col_r.push_back(rb); col_q.push_back(3'b100); i--; end
                default: begin col_r.push_back(3'b100); col_q.push_back(qb); j--; end
            endcase
            n++;
        end
        exp_ra = '1;
        exp_qa = '1;
        for (int k = 0; k < n; k++) begin
            exp_ra[3*k +: 3] = col_r[n-1-k];
            exp_qa[3*k +: 3] = col_q[n-1-k];
        end
        exp_lat  = cells + n + 1;
        exp_best = best;
    endtask

    always begin
        @(posedge clk);
        if (running && !start) edges++;
        #1;
        if (start) begin
            check("reset ready", 32'(ready), 32'd0);
            check("reset R_aligned", 32'(R_aligned), 32'd0);
            check("reset Q_aligned", 32'(Q_aligned), 32'd0);
`ifdef BSW_SCORE_OUT_EN
            check("reset best_score", 32'(best_score), 32'd0);
`endif
        end else if (running) begin
            check("ready timing", 32'(ready), 32'(edges >= exp_lat));
            if (ready) begin
                check("R_aligned", 32'(R_aligned), 32'(exp_ra));
                check("Q_aligned", 32'(Q_aligned), 32'(exp_qa));
`ifdef BSW_SCORE_OUT_EN
                check("best_score", 32'(best_score), 32'(exp_best));
`endif
            end
        end
    end

    task automatic run_case(input logic [23:0] r, input logic [23:0] q, input int extra,
                            input bit perturb);
        @(negedge clk);
        start   = 1'b1;
        running = 1'b0;
        R = r;
        Q = q;
        model(r, q);
        repeat (2) @(negedge clk);
        edges   = -1;
        running = 1'b1;
        start   = 1'b0;
        @(negedge clk);
        if (perturb) begin
            R = ~r;
            Q = r ^ 24'h5a5a5a;
        end
        repeat (exp_lat + extra) @(negedge clk);
    endtask

    task automatic abort_check(input string tag);
        start   = 1'b1;
        running = 1'b0;
        #1;
        check({tag, " ready"}, 32'(ready), 32'd0);
        check({tag, " R_aligned"}, 32'(R_aligned), 32'd0);
        check({tag, " Q_aligned"}, 32'(Q_aligned), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);

        model(ACGT, ACGT);
        check("model identical R", 32'(exp_ra), 32'h7688688);
        check("model identical Q", 32'(exp_qa), 32'h7688688);
        check("model identical latency", 32'(exp_lat), 32'd31);
        check("model identical score", 32'(exp_best), 32'd16);
        model(ACGT, ONEMM);
        check("model mismatch R", 32'(exp_ra), 32'h7688688);
        check("model mismatch Q", 32'(exp_qa), 32'h7688088);
        check("model mismatch score", 32'(exp_best), 32'd13);
        model(24'h000000, ALLC);
        check("model nomatch R", 32'(exp_ra), 32'h7ffffff);
        check("model nomatch latency", 32'(exp_lat), 32'd23);

        run_case(ACGT, ACGT, 5, 1'b0);
        run_case(ACGT, ONEMM, 5, 1'b0);
        run_case(24'h000000, ALLC, 5, 1'b0);
        run_case(24'hffffff, 24'hffffff, 5, 1'b0);
        run_case(INDEL, ACGT, 5, 1'b0);

        // Abort mid-fill, then a clean identical-reads run.
        @(negedge clk);
        start = 1'b1;
        R = ACGT;
        Q = ACGT;
        model(ACGT, ACGT);
        repeat (2) @(negedge clk);
        edges   = -1;
        running = 1'b1;
        start   = 1'b0;
        repeat (6) @(negedge clk);
        abort_check("fill abort");
        run_case(ACGT, ACGT, 5, 1'b0);

        run_case(ACGT, ONEMM, 5, 1'b1);

        // Hold for 100 cycles after ready, then abort asynchronously from DONE.
        run_case(ACGT, ACGT, 100, 1'b0);
        abort_check("done abort");
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/banded_sw_accelerator.md
Name: banded_sw_accelerator

Overview:
- Banded Smith-Waterman local aligner for two fixed-length DNA reads of LEN bases, 3 bits per base.
- Sits behind the memory-mapped peripheral.
- Host writes R and Q, pulses start, polls ready, then reads the gapped aligned strings R_aligned and Q_aligned.
- Only matrix cells with |i-j| <= BAND are computed.

Parameters:
- LEN, 8: bases per read.
- BAND, 1: band half-width.
- MATCH, 2: match reward.
- MISMATCH, 1: mismatch penalty (subtracted).
- GAP, 1: linear gap penalty (subtracted).
- SW, 6: signed score width.

Ports:
- clk, input, 1: sole clock, rising edge.
- start, input, 1: asynchronous active-high reset. Deassertion starts a new alignment.
- R, input, 3*LEN: reference read. Base k occupies bits [3k+2:3k].
- Q, input, 3*LEN: query read, same packing as R.
- R_aligned, output, 3*(LEN+1): aligned reference string.
- Q_aligned, output, 3*(LEN+1): aligned query string.
- ready, output, 1: result valid.

Behaviour:
- Reset state: while start=1, asynchronously force ready=0, R_aligned=0, Q_aligned=0, FSM=IDLE. Asserting start mid-operation aborts immediately.
- Encoding:
  - Input bases: A=000, C=001, G=010, T=011; other codes compare as mismatch.
  - Output symbols: bases as above, gap=100, pad=111.
- IDLE:
  - On the first rising edge with start=0, latch R and Q into internal registers and enter FILL.
  - Later changes to R and Q are ignored.
- Score matrix:
  - H(0,*) = H(*,0) = 0. i indexes R, j indexes Q, both 1..LEN.
  - H(i,j) = max(0, diag, up, left), where diag = H(i-1,j-1) + (R[i]==Q[j] ? MATCH : -MISMATCH), up = H(i-1,j) - GAP, left = H(i,j-1) - GAP.
  - Out-of-band neighbours count as 0.
  - Store a 2-bit pointer per cell: ZERO, DIAG, UP, LEFT.
  - Tie priority: DIAG > UP > LEFT > ZERO, except when the max is 0, which gives pointer ZERO.
- FILL:
  - One in-band cell per cycle, row-major (i outer, j ascending).
  - 22 cells for LEN=8, BAND=1.
  - Track the best cell; update only on a strictly greater score, so the first maximum in row-major order wins.
- TRACE: start at the best cell and emit one column per cycle.
  - DIAG: emit R[i] / Q[j], then i--, j--.
  - UP: emit R[i] / gap, then i--.
  - LEFT: emit gap / Q[j], then j--.
  - Stop when the current cell's pointer is ZERO or score is 0, or after LEN+1 columns have been emitted (truncation).
  - If the best score is 0, emit nothing.
- Output packing:
  - Column 0 is the leftmost aligned column and occupies bits [2:0].
  - Unused high columns hold pad 111.
  - Implement by building in reverse and shifting.
- DONE:
  - Drive ready=1 and hold both outputs stable until start is reasserted.
  - ready rises exactly CELLS + L + 1 rising edges after the IDLE exit edge, where CELLS is the in-band cell count and L is the number of emitted columns.
- Arithmetic: signed SW-bit scores, floored at 0, no overflow for the defaults (maximum score 16).

Optional Feature:
- Macro BSW_SCORE_OUT_EN.
- When defined: adds output port best_score, SW bits. It is 0 under reset and holds the best H value from DONE onward.
- When undefined: the port and its register are absent. Alignment behaviour is identical either way.

Decomposition:
- Package bsw_pkg holds:
  - base and symbol codes (A, C, G, T, GAP, PAD);
  - pointer enum (ZERO, DIAG, UP, LEFT);
  - FSM state enum (IDLE, FILL, TRACE, DONE);
  - default scoring constants.
- One natural sub-module: bsw_cell, a combinational max-of-four that produces score and pointer from diag, up, left and the match flag.

Test Plan:
- Identical reads: R=Q=0x688688 (ACGTACGT).
  - R_aligned = Q_aligned = 0x7688688.
  - ready rises at 22+8+1 = 31 edges; best_score = 16.
- Single mismatch: R=0x688688, Q=0x688088.
  - R_aligned = 0x7688688, Q_aligned = 0x7688088.
  - No gaps; best_score = 13.
- No match: R=0x000000, Q=0x249249.
  - R_aligned = Q_aligned = 0x7FFFFFF; ready at 23 edges.
- Abort: assert start during FILL cycle 5.
  - ready, R_aligned and Q_aligned read 0 in the same cycle.
  - On release with the identical-reads inputs, the first scenario's results are produced.
- Input stability: change R and Q after the IDLE exit edge.
  - Results match the values latched at that edge.
- Hold: keep start=0 for 100 cycles after ready.
  - ready stays 1 and outputs are unchanged.
